// File: rtl/lcm_pkg.sv
// Shared types and width helpers for the LCM co-processor.
// The controller state encoding and the result/counter widths derived from the operand width.
package lcm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lcm_state_e;

    // The LCM of two w-bit values is at most their product, so it fits in 2*w bits.
    function automatic int lcm_rw(input int w);
        return 2 * w;
    endfunction

    // The step count never exceeds a+b-2, which is below 2^(w+1).
    function automatic int lcm_cw(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/lcm_datapath.sv
// Operand registers, running multiples x/y, step counter and comparator.
// On each step, the smaller of x/y is advanced by its own operand.
module lcm_datapath
    import lcm_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int RW = lcm_rw(WIDTH),
    localparam int CW = lcm_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             lt,
    output logic             eq,
    output logic [RW-1:0]    x,
    output logic [CW-1:0]    steps
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [RW-1:0]    r_x;
    logic [RW-1:0]    r_y;
    logic [CW-1:0]    r_steps;
    logic             w_lt;

    assign w_lt = (r_x < r_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_steps <= '0;
        end else if (load) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_x     <= RW'(in_a);
            r_y     <= RW'(in_b);
            r_steps <= '0;
        end else if (step) begin
            // x and y never pass the LCM, so these additions cannot wrap.
            if (w_lt) begin
                r_x <= r_x + RW'(r_a);
            end else begin
                r_y <= r_y + RW'(r_b);
            end
            r_steps <= r_steps + CW'(1);
        end
    end

    assign lt    = w_lt;
    assign eq    = (r_x == r_y);
    assign x     = r_x;
    assign steps = r_steps;

endmodule

// File: rtl/lcm_engine.sv
// LCM co-processor: valid/ready command and result handshake around the
// repeated-addition datapath, with zero-operand error, step count and abort.
module lcm_engine
    import lcm_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int RW = lcm_rw(WIDTH),
    localparam int CW = lcm_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    out_lcm,
    output logic             out_err,
    output logic [CW-1:0]    out_steps,
    output logic             busy
);

    lcm_state_e    r_state;
    lcm_state_e    w_next_state;
    logic          w_load;
    logic          w_step;
    logic          w_latch;
    logic          w_zero_err;
    logic          w_zero_out;
    logic          w_lt;
    logic          w_eq;
    logic          w_gt;
    logic [RW-1:0] w_x;
    logic [CW-1:0] w_steps;
    logic [RW-1:0] r_lcm;
    logic          r_err;
    logic [CW-1:0] r_steps;

    lcm_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .step  (w_step),
        .in_a  (in_a),
        .in_b  (in_b),
        .lt    (w_lt),
        .eq    (w_eq),
        .x     (w_x),
        .steps (w_steps)
    );

    assign w_gt = !w_lt && !w_eq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_latch      = 1'b0;
        w_zero_err   = 1'b0;
        w_zero_out   = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_load = 1'b1;
                    if (in_a == '0 || in_b == '0) begin
                        w_next_state = DONE;
                        w_zero_err   = 1'b1;
                    end else begin
                        w_next_state = RUN;
                    end
                end
            end
            RUN: begin
                if (w_eq) begin
                    w_next_state = DONE;
                    w_latch      = 1'b1;
                end else begin
                    // Advance whichever side is behind.
                    w_step = w_lt || w_gt;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                    w_zero_out   = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        // Abort overrides every handshake in the same cycle.
        if (clear) begin
            w_next_state = IDLE;
            w_load       = 1'b0;
            w_step       = 1'b0;
            w_latch      = 1'b0;
            w_zero_err   = 1'b0;
            w_zero_out   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lcm   <= '0;
            r_err   <= 1'b0;
            r_steps <= '0;
        end else if (w_zero_out) begin
            r_lcm   <= '0;
            r_err   <= 1'b0;
            r_steps <= '0;
        end else if (w_zero_err) begin
            r_lcm   <= '0;
            r_err   <= 1'b1;
            r_steps <= '0;
        end else if (w_latch) begin
            r_lcm   <= w_x;
            r_err   <= 1'b0;
            r_steps <= w_steps;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN);
    assign out_lcm   = r_lcm;
    assign out_err   = r_err;
    assign out_steps = r_steps;

endmodule

// File: tb/tb_lcm_engine.sv
// Directed and randomized bench for lcm_engine, checked against a gcd-based
// arithmetic model of the LCM, step count and result latency.
module tb_lcm_engine;

    localparam int WIDTH = 8;
    localparam int RW    = 2 * WIDTH;
    localparam int CW    = WIDTH + 1;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             clear     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_a      = '0;
    logic [WIDTH-1:0] in_b      = '0;
    logic             in_ready;
    logic             out_valid;
    logic [RW-1:0]    out_lcm;
    logic             out_err;
    logic [CW-1:0]    out_steps;
    logic             busy;

    int checks = 0;
    int errors = 0;

    lcm_engine #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lcm   (out_lcm),
        .out_err   (out_err),
        .out_steps (out_steps),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic longint ref_gcd(input longint a, input longint b);
        longint p = a;
        longint q = b;
        longint t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    function automatic longint ref_lcm(input longint a, input longint b);
        if (a == 0 || b == 0) return 0;
        return (a * b) / ref_gcd(a, b);
    endfunction

    // x visits a, 2a, ..., lcm and y visits b, 2b, ..., lcm: one addition per move.
    function automatic longint ref_steps(input longint a, input longint b);
        if (a == 0 || b == 0) return 0;
        return ref_lcm(a, b) / a + ref_lcm(a, b) / b - 2;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one operand pair; returns at posedge+1 right after the accept edge.
    task automatic send(input int a, input int b, input string tag);
        int w = 0;
        while (in_ready !== 1'b1 && w < 1000) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk({tag, "_ready_before_accept"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_a     = WIDTH'(a);
        in_b     = WIDTH'(b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts falling edges after the accept edge until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (out_valid !== 1'b1 && lat < 1000);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_valid_dropped"}, 64'(out_valid), 64'(0));
        chk({tag, "_ready_again"}, 64'(in_ready), 64'(1));
    endtask

    task automatic run_op(input int a, input int b, input string tag, input int hold);
        int     lat;
        longint exp_lat;
        send(a, b, tag);
        wait_valid(lat);
        exp_lat = (a == 0 || b == 0) ? 1 : ref_steps(a, b) + 2;
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_lcm"}, 64'(out_lcm), 64'(ref_lcm(a, b)));
        chk({tag, "_err"}, 64'(out_err), 64'((a == 0 || b == 0) ? 1 : 0));
        chk({tag, "_steps"}, 64'(out_steps), 64'(ref_steps(a, b)));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
            chk({tag, "_hold_lcm"}, 64'(out_lcm), 64'(ref_lcm(a, b)));
        end
        handshake(tag);
    endtask

    initial begin
        int lat;
        int ra;
        int rb;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_lcm", 64'(out_lcm), 64'(0));
        chk("rst_err", 64'(out_err), 64'(0));
        chk("rst_steps", 64'(out_steps), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // Directed cases
        run_op(4, 6, "a4b6", 0);
        run_op(7, 7, "a7b7", 0);
        run_op(1, 9, "a1b9", 0);
        run_op(0, 5, "a0b5", 2);
        run_op(5, 0, "a5b0", 0);
        run_op(255, 254, "a255b254", 0);

        // Backpressure, with in_valid pulses that must be ignored
        send(3, 5, "bp");
        in_valid = 1'b1;
        in_a     = 8'd2;
        in_b     = 8'd2;
        @(negedge clk);
        chk("bp_busy", 64'(busy), 64'(1));
        chk("bp_not_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_lcm", 64'(out_lcm), 64'(ref_lcm(3, 5)));
        chk("bp_steps", 64'(out_steps), 64'(ref_steps(3, 5)));
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(out_valid), 64'(1));
            chk("bp_hold_lcm", 64'(out_lcm), 64'(15));
            chk("bp_hold_steps", 64'(out_steps), 64'(6));
        end
        in_valid = 1'b0;
        handshake("bp");
        run_op(6, 4, "after_bp", 0);

        // Synchronous abort mid-RUN
        send(200, 199, "clr");
        repeat (3) @(posedge clk);
        #1;
        chk("clr_busy_before", 64'(busy), 64'(1));
        clear = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr_in_ready", 64'(in_ready), 64'(1));
        chk("clr_busy", 64'(busy), 64'(0));
        chk("clr_valid", 64'(out_valid), 64'(0));
        chk("clr_lcm", 64'(out_lcm), 64'(0));
        repeat (5) begin
            @(negedge clk);
            chk("clr_no_valid", 64'(out_valid), 64'(0));
        end

        // Asynchronous reset mid-RUN
        send(200, 199, "arst");
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_valid", 64'(out_valid), 64'(0));
        chk("arst_lcm", 64'(out_lcm), 64'(0));
        chk("arst_err", 64'(out_err), 64'(0));
        chk("arst_steps", 64'(out_steps), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        run_op(4, 6, "after_arst", 0);

        // Randomized operand pairs with random backpressure
        for (int i = 0; i < 12; i++) begin
            ra = int'($urandom_range(1, 255));
            rb = int'($urandom_range(1, 255));
            if (i == 5) ra = 0;
            run_op(ra, rb, $sformatf("rand%0d_a%0d_b%0d", i, ra, rb), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcm_engine.md
Name: lcm_engine

Overview:
- Parametrised, self-contained LCM co-processor. Computes LCM(a,b) by the repeated-addition method: x starts at a, y starts at b, and the smaller one is bumped by its own operand until x equals y.
- Merges the controller FSM and the x/y datapath into one block, generalised to WIDTH bits.
- Adds a valid/ready handshake on input and output, zero-operand error detection, a step counter and a synchronous abort.
- Sits between the command interface and the result bus of the LCM processor.

Parameters:
- WIDTH, 8, operand width in bits; must be at least 2.
- RW (localparam), 2*WIDTH, result width; LCM of two WIDTH-bit values always fits, so overflow is impossible.
- CW (localparam), WIDTH+1, step-counter width; additions never exceed a+b-2 < 2^(WIDTH+1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort; returns the block to IDLE
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- in_a  in  WIDTH  operand a
- in_b  in  WIDTH  operand b
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_lcm  out  RW  LCM result
- out_err  out  1  an operand was zero
- out_steps  out  CW  number of additions performed
- busy  out  1  high in RUN

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, x=0, y=0, a_r=0, b_r=0, steps=0, out_valid=0, out_err=0, out_lcm=0, out_steps=0, busy=0. in_ready is 1 once reset is released.
- States and handshake:
  - IDLE: in_ready=1. On in_valid&&in_ready: capture a_r=in_a, b_r=in_b, x=in_a, y=in_b (zero-extended to RW), steps=0.
    - If in_a==0 or in_b==0: go to DONE with out_err=1, out_lcm=0, out_steps=0.
    - Otherwise: go to RUN.
  - RUN: busy=1, in_ready=0. Exactly one compare-and-add per cycle:
    - x==y: latch out_lcm=x, out_steps=steps, out_err=0; go to DONE.
    - x<y: x<=x+a_r, steps++.
    - x>y: y<=y+b_r, steps++.
  - DONE: out_valid=1; out_lcm, out_err and out_steps are held stable. On out_valid&&out_ready go to IDLE; out_valid drops the next cycle.
- Latency:
  - Accept at edge T. out_valid is high in cycle T+1+N+1, where N is the number of additions (one RUN cycle per addition plus one final equality cycle).
  - Zero-operand case: out_valid is high at T+1.
- in_valid while not in IDLE: ignored. No capture, no effect on the current operation.
- No back-to-back: in IDLE the cycle after an output handshake, in_ready=1 again; at most one result every N+3 cycles.
- clear:
  - From any state, the next state is IDLE. out_valid=0, busy=0.
  - Datapath registers are not required to clear; outputs read 0 in IDLE (out_lcm, out_err and out_steps are zeroed on clear).
  - clear has priority over in_valid and out_ready in the same cycle.
- rst_n low mid-RUN or mid-DONE: immediate return to reset values. The partial result is discarded and is never presented.
- Arithmetic is unsigned, in RW bits; the x/y compare is an unsigned RW-bit compare.
- A stable result is guaranteed while out_valid=1 and out_ready=0, for any number of cycles.

Decomposition:
- Package lcm_pkg: the state enumeration (IDLE, RUN, DONE) and the localparam width functions (RW, CW derived from WIDTH).
- One sub-module, lcm_datapath:
  - Holds a_r, b_r, x, y, steps and the comparator.
  - Inputs: load, step.
  - Outputs: lt, eq.
- lcm_engine keeps the FSM and the handshake logic.

Test Plan:
- a=4, b=6 (WIDTH=8) -> out_lcm=12, out_steps=3, out_err=0; out_valid 5 cycles after the accept edge.
- a=7, b=7 -> out_lcm=7, out_steps=0; out_valid 2 cycles after accept. a=1, b=9 -> 9, steps=8.
- a=0, b=5 -> out_err=1, out_lcm=0, out_steps=0; out_valid 1 cycle after accept. Repeat with a=5, b=0.
- a=255, b=254 -> out_lcm=64770, out_steps=507. Checks the full-width result and counter range with no wrap.
- Backpressure: a=3, b=5, out_ready held low for 10 cycles -> out_valid and out_lcm=15 stay stable. in_valid pulsed with a=2, b=2 during RUN/DONE is ignored. The next accepted pair yields its own result.
- Abort: clear asserted 3 cycles into RUN on 200/199 -> IDLE next cycle, in_ready=1, no out_valid. Then rst_n pulsed low mid-RUN -> all outputs read their reset values immediately. A subsequent 4/6 still returns 12.
